// File: rtl/ld_rs.sv
// rtl/ld_rs.sv - reservation station for the LD unit: dispatch, CDB wakeup, in-order-by-index issue, free on completion
module ld_rs #(
    parameter int         NUM_ENTRIES = 4,
    parameter logic [5:0] RS_BASE     = 6'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_valid,
    input  logic [3:0]  disp_op,
    input  logic        disp_rdy0,
    input  logic [5:0]  disp_tag0,
    input  logic [15:0] disp_val0,
    input  logic        disp_rdy1,
    input  logic [5:0]  disp_tag1,
    input  logic [15:0] disp_val1,
    output logic [5:0]  disp_tag,
    output logic        full,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [15:0] cdb_data,
    output logic        ld_valid,
    output logic [5:0]  ld_rs_num,
    output logic [3:0]  ld_op,
    output logic [15:0] ld_val0,
    output logic [15:0] ld_val1,
    input  logic        ld_busy,
    input  logic        done_valid,
    input  logic [5:0]  done_rs_num
);
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_ISSUED} state_t;

    state_t      st     [NUM_ENTRIES];
    state_t      st_nxt [NUM_ENTRIES];
    logic [3:0]  e_op   [NUM_ENTRIES];
    logic        e_rdy0 [NUM_ENTRIES];
    logic        e_rdy1 [NUM_ENTRIES];
    logic [5:0]  e_tag0 [NUM_ENTRIES];
    logic [5:0]  e_tag1 [NUM_ENTRIES];
    logic [15:0] e_val0 [NUM_ENTRIES];
    logic [15:0] e_val1 [NUM_ENTRIES];
    logic        hit0   [NUM_ENTRIES];
    logic        hit1   [NUM_ENTRIES];

    logic          free_found, rdy_found, disp_we, issue;
    logic [IW-1:0] free_idx, rdy_idx;
    logic          d_rdy0, d_rdy1;
    logic [15:0]   d_val0, d_val1;

    // Dispatch-time operands, including a same-cycle CDB bypass
    always_comb begin
        d_rdy0 = disp_rdy0 || (cdb_valid && cdb_tag == disp_tag0);
        d_rdy1 = disp_rdy1 || (cdb_valid && cdb_tag == disp_tag1);
        d_val0 = disp_rdy0 ? disp_val0 : cdb_data;
        d_val1 = disp_rdy1 ? disp_val1 : cdb_data;
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hit0[i] = cdb_valid && (st[i] == S_WAIT) && !e_rdy0[i] && (e_tag0[i] == cdb_tag);
            hit1[i] = cdb_valid && (st[i] == S_WAIT) && !e_rdy1[i] && (e_tag1[i] == cdb_tag);
            if (!free_found && st[i] == S_FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (!rdy_found && st[i] == S_READY) begin
                rdy_found = 1'b1;
                rdy_idx   = IW'(i);
            end
        end
        full     = !free_found;
        disp_tag = free_found ? RS_BASE + 6'(free_idx) : RS_BASE;
        disp_we  = disp_valid && free_found;
        issue    = !ld_busy && !ld_valid && rdy_found;
    end

    // Per-entry lifecycle; each transition acts only on entries in its own state
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            st_nxt[i] = st[i];
            case (st[i])
                S_FREE:   if (disp_we && free_idx == IW'(i))
                              st_nxt[i] = (d_rdy0 && d_rdy1) ? S_READY : S_WAIT;
                S_WAIT:   if ((e_rdy0[i] || hit0[i]) && (e_rdy1[i] || hit1[i]))
                              st_nxt[i] = S_READY;
                S_READY:  if (issue && rdy_idx == IW'(i))
                              st_nxt[i] = S_ISSUED;
                S_ISSUED: if (done_valid && done_rs_num == RS_BASE + 6'(i))
                              st_nxt[i] = S_FREE;
                default:  st_nxt[i] = S_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) st[i] <= S_FREE;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) st[i] <= st_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                e_op[i]   <= '0;
                e_rdy0[i] <= 1'b0;
                e_rdy1[i] <= 1'b0;
                e_tag0[i] <= '0;
                e_tag1[i] <= '0;
                e_val0[i] <= '0;
                e_val1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (disp_we && free_idx == IW'(i)) begin
                    e_op[i]   <= disp_op;
                    e_rdy0[i] <= d_rdy0;
                    e_rdy1[i] <= d_rdy1;
                    e_tag0[i] <= disp_tag0;
                    e_tag1[i] <= disp_tag1;
                    e_val0[i] <= d_val0;
                    e_val1[i] <= d_val1;
                end else begin
                    if (hit0[i]) begin
                        e_rdy0[i] <= 1'b1;
                        e_val0[i] <= cdb_data;
                    end
                    if (hit1[i]) begin
                        e_rdy1[i] <= 1'b1;
                        e_val1[i] <= cdb_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_valid  <= 1'b0;
            ld_rs_num <= '0;
            ld_op     <= '0;
            ld_val0   <= '0;
            ld_val1   <= '0;
        end else begin
            ld_valid <= issue;
            if (issue) begin
                ld_rs_num <= RS_BASE + 6'(rdy_idx);
                ld_op     <= e_op[rdy_idx];
                ld_val0   <= e_val0[rdy_idx];
                ld_val1   <= e_val1[rdy_idx];
            end
        end
    end
endmodule
